// File: rtl/cpu_sequencer.sv
// Control FSM that steps the single-issue CPU through fetch, decode, execute and write-back.
// Handles the imem handshake, multi-cycle ALU ops with a timeout, sticky halt, and the retired count.
module cpu_sequencer #(
  parameter int CNT_WIDTH       = 32,
  parameter int MAX_EXEC_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 imem_ready,
  input  logic                 is_halt,
  input  logic                 is_branch,
  input  logic                 is_multicycle,
  input  logic                 alu_done,
  output logic                 imem_req,
  output logic                 inst_latch,
  output logic                 alu_start,
  output logic                 pc_enable,
  output logic                 reg_write_enable,
  output logic                 halted,
  output logic                 exec_error,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    DECODE     = 3'd1,
    EXECUTE    = 3'd2,
    WRITE_BACK = 3'd3,
    HALTED     = 3'd4
  } state_t;

  // exec_cnt holds the number of EXECUTE cycles already completed, so the
  // MAX_EXEC_CYCLES-th cycle is the one where it equals EXEC_LIMIT.
  localparam logic [7:0] EXEC_LIMIT = 8'(MAX_EXEC_CYCLES - 1);

  state_t               state_q, state_d;
  logic [7:0]           exec_cnt_q, exec_cnt_d;
  logic                 halted_q, exec_error_q;
  logic [CNT_WIDTH-1:0] retired_q;
  logic                 set_error, retire;

  always_comb begin
    state_d          = state_q;
    exec_cnt_d       = '0;
    set_error        = 1'b0;
    retire           = 1'b0;
    imem_req         = 1'b0;
    inst_latch       = 1'b0;
    alu_start        = 1'b0;
    pc_enable        = 1'b0;
    reg_write_enable = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = run;
        if (run && imem_ready) begin
          inst_latch = 1'b1;
          state_d    = DECODE;
        end
      end
      DECODE: state_d = is_halt ? HALTED : EXECUTE;
      EXECUTE: begin
        if (!is_multicycle) begin
          state_d = WRITE_BACK;
        end else begin
          alu_start = (exec_cnt_q == 8'd0);
          // alu_done on the limit cycle still completes the op
          if ((exec_cnt_q != 8'd0) && alu_done) begin
            state_d = WRITE_BACK;
          end else if (exec_cnt_q >= EXEC_LIMIT) begin
            state_d   = HALTED;
            set_error = 1'b1;
          end else begin
            exec_cnt_d = exec_cnt_q + 8'd1;
          end
        end
      end
      WRITE_BACK: begin
        pc_enable        = 1'b1;
        reg_write_enable = !is_branch;
        retire           = 1'b1;
        state_d          = FETCH;
      end
      HALTED: state_d = HALTED;
      default: begin
        state_d   = HALTED;
        set_error = 1'b1;
      end
    endcase
    if (reset) begin
      imem_req         = 1'b0;
      inst_latch       = 1'b0;
      alu_start        = 1'b0;
      pc_enable        = 1'b0;
      reg_write_enable = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      exec_cnt_q   <= '0;
      halted_q     <= 1'b0;
      exec_error_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q    <= state_d;
      exec_cnt_q <= exec_cnt_d;
      if (state_d == HALTED) halted_q <= 1'b1;
      if (set_error) exec_error_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  assign state         = state_q;
  assign halted        = halted_q;
  assign exec_error    = exec_error_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus pushes expected strobe events,
// a negedge monitor pops and compares each event the DUT presents.
module tb_cpu_sequencer;

  localparam int CW   = 4;
  localparam int MAXE = 16;

  logic          clk = 1'b0;
  logic          reset, run, imem_ready, is_halt, is_branch, is_multicycle, alu_done;
  logic          imem_req, inst_latch, alu_start, pc_enable, reg_write_enable;
  logic          halted, exec_error;
  logic [2:0]    state;
  logic [CW-1:0] retired_count;

  cpu_sequencer #(.CNT_WIDTH(CW), .MAX_EXEC_CYCLES(MAXE)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_ready(imem_ready),
    .is_halt(is_halt), .is_branch(is_branch), .is_multicycle(is_multicycle),
    .alu_done(alu_done), .imem_req(imem_req), .inst_latch(inst_latch),
    .alu_start(alu_start), .pc_enable(pc_enable), .reg_write_enable(reg_write_enable),
    .halted(halted), .exec_error(exec_error), .state(state), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // flags = {inst_latch, alu_start, pc_enable, reg_write_enable, halted, exec_error}
  typedef struct {
    string         name;
    int            gap;
    logic [2:0]    st;
    logic [5:0]    flags;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] model_cnt = '0;
  int            idle_cycles = 0;
  int            gap_cnt = 0;
  bit            halt_seen = 1'b0;

  task automatic push_exp(input string name, input int gap, input logic [2:0] st,
                          input logic [5:0] flags);
    exp_t e;
    e.name  = name;
    e.gap   = gap;
    e.st    = st;
    e.flags = flags;
    e.cnt   = model_cnt;
    exp_q.push_back(e);
  endtask

  // gap = negedges since the previous event, so event timing is checked too
  always @(negedge clk) begin
    logic [5:0] obs;
    exp_t       e;
    if (reset) begin
      gap_cnt   = 0;
      halt_seen = 1'b0;
    end else begin
      gap_cnt++;
      obs = {inst_latch, alu_start, pc_enable, reg_write_enable, halted, exec_error};
      if (inst_latch || alu_start || pc_enable || reg_write_enable || (halted && !halt_seen)) begin
        if (halted) halt_seen = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_event: got state=%0d flags=%b cnt=%0d, required no event",
                   state, obs, retired_count);
        end else begin
          e = exp_q.pop_front();
          if (gap_cnt != e.gap || state != e.st || obs != e.flags || retired_count != e.cnt) begin
            errors++;
            $display("[TB] FAIL %s: got gap=%0d state=%0d flags=%b cnt=%0d, required gap=%0d state=%0d flags=%b cnt=%0d",
                     e.name, gap_cnt, state, obs, retired_count, e.gap, e.st, e.flags, e.cnt);
          end
        end
        gap_cnt = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d pending events (first %s), required 0",
               name, exp_q.size(), exp_q[0].name);
    end
    exp_q.delete();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    run = 1'b1; imem_ready = 1'b1; alu_done = 1'b0;
    is_halt = 1'b0; is_branch = 1'b0; is_multicycle = 1'b0;
    @(negedge clk);
    check_output("reset_state", 32'(state), 0);
    check_output("reset_count", 32'(retired_count), 0);
    check_output("reset_halted", 32'({halted, exec_error}), 0);
    check_output("reset_strobes",
                 32'({imem_req, inst_latch, alu_start, pc_enable, reg_write_enable}), 0);
    tick;
    check_drained("leftover_events");
    imem_ready  = 1'b0;
    reset       = 1'b0;
    model_cnt   = '0;
    idle_cycles = 0;
  endtask

  // One instruction from its first FETCH cycle; k = cycles from alu_start to alu_done.
  task automatic apply_stimulus(input string name, input logic br, input logic mc,
                                input logic hlt, input logic early, input logic tmo,
                                input int k, input int ready_wait);
    is_halt = hlt; is_branch = br; is_multicycle = mc; alu_done = 1'b0; run = 1'b1;
    push_exp({name, "_latch"}, 1 + ready_wait + idle_cycles, 3'd0, 6'b100000);
    idle_cycles = 0;
    if (hlt) begin
      push_exp({name, "_halt"}, 2, 3'd4, 6'b000010);
    end else if (!mc) begin
      push_exp({name, "_wb"}, 3, 3'd3, {2'b00, 1'b1, !br, 2'b00});
      model_cnt++;
    end else begin
      push_exp({name, "_start"}, 2, 3'd2, 6'b010000);
      if (tmo) begin
        push_exp({name, "_timeout"}, MAXE, 3'd4, 6'b000011);
      end else begin
        push_exp({name, "_wb"}, k + 1, 3'd3, {2'b00, 1'b1, !br, 2'b00});
        model_cnt++;
      end
    end
    for (int i = 0; i < ready_wait; i++) begin
      imem_ready = 1'b0;
      @(negedge clk);
      check_output({name, "_wait_req"}, 32'(imem_req), 1);
      check_output({name, "_wait_state"}, 32'(state), 0);
      tick;
    end
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0;
    tick;
    if (!hlt) begin
      if (!mc) begin
        tick;
        tick;
      end else if (tmo) begin
        repeat (MAXE) tick;
      end else begin
        alu_done = early;
        for (int j = 1; j <= k; j++) begin
          tick;
          alu_done = 1'b0;
        end
        alu_done = 1'b1;
        tick;
        alu_done = 1'b0;
        tick;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; run = 1'b0; imem_ready = 1'b0; alu_done = 1'b0;
    is_halt = 1'b0; is_branch = 1'b0; is_multicycle = 1'b0;
    do_reset();

    repeat (3) apply_stimulus("add", 0, 0, 0, 0, 0, 0, 0);
    check_output("retired_after_3", 32'(retired_count), 3);

    apply_stimulus("add_wait", 0, 0, 0, 0, 0, 0, 5);

    run = 1'b0; imem_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_output("idle_req", 32'(imem_req), 0);
      check_output("idle_state", 32'(state), 0);
      tick;
    end
    idle_cycles = 5;
    apply_stimulus("add_after_idle", 0, 0, 0, 0, 0, 0, 0);

    apply_stimulus("br", 1, 0, 0, 0, 0, 0, 0);
    check_output("retired_after_br", 32'(retired_count), 6);

    apply_stimulus("mpy_k3", 0, 1, 0, 0, 0, 3, 0);
    apply_stimulus("mpy_early", 0, 1, 0, 1, 0, 2, 0);
    apply_stimulus("mpy_limit", 0, 1, 0, 0, 0, MAXE - 1, 0);
    check_output("limit_not_halted", 32'({halted, exec_error}), 0);

    repeat (6) apply_stimulus("add_fill", 0, 0, 0, 0, 0, 0, 0);
    check_output("retired_15", 32'(retired_count), 15);

    // multi-cycle op interrupted by reset in its second EXECUTE cycle
    is_multicycle = 1'b1; is_halt = 1'b0; is_branch = 1'b0; run = 1'b1;
    push_exp("mid_latch", 1, 3'd0, 6'b100000);
    push_exp("mid_start", 2, 3'd2, 6'b010000);
    imem_ready = 1'b1;
    tick;
    imem_ready = 1'b0;
    tick;
    tick;
    #2 reset = 1'b1;
    #1;
    check_output("async_state", 32'(state), 0);
    check_output("async_count", 32'(retired_count), 0);
    check_output("async_strobes", 32'({imem_req, alu_start, pc_enable}), 0);
    do_reset();

    repeat (15) apply_stimulus("add_wrap", 0, 0, 0, 0, 0, 0, 0);
    check_output("pre_wrap", 32'(retired_count), 15);
    apply_stimulus("add_wrap_last", 0, 0, 0, 0, 0, 0, 0);
    check_output("wrap", 32'(retired_count), 0);

    apply_stimulus("add_pre_halt", 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus("halt_op", 0, 0, 1, 0, 0, 0, 0);
    run = 1'b1; imem_ready = 1'b1;
    repeat (4) tick;
    check_output("halt_state", 32'(state), 4);
    check_output("halt_flags", 32'({halted, exec_error}), 2);
    check_output("halt_count", 32'(retired_count), 1);

    do_reset();
    apply_stimulus("mpy_timeout", 0, 1, 0, 0, 1, 0, 0);
    run = 1'b1; imem_ready = 1'b1; alu_done = 1'b1;
    repeat (6) tick;
    check_output("timeout_state", 32'(state), 4);
    check_output("timeout_flags", 32'({halted, exec_error}), 3);
    check_output("timeout_pc", 32'(pc_enable), 0);

    repeat (2) tick;
    check_drained("final_events");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
